brownout_reset_sequencer: RTL
=============================

# brownout_reset_sequencer

Digital stage directly downstream of the brownout detector, in the dvdd domain. It synchronizes and debounces the detector's asynchronous `outb` and `vunder` outputs. It turns them into a clean system reset with a guaranteed post-recovery hold time, a power-good indication, sticky fault flags and a saturating brownout event count for firmware.

## Interface
- `DEB_CYCLES`, default 4: consecutive identical synchronized samples required to change a debounced level; 2..255.
- `HOLD_CYCLES`, default 1024: cycles `sys_resetb` stays low after brownout clears; 1..65535.
- `CNT_W`, default 8: event counter width.
- `clk` in 1: system clock.
- `resetb` in 1: asynchronous active-low reset.
- `ena` in 1: block enable, synchronous to `clk`.
- `outb` in 1: detector output, asynchronous; low means brownout.
- `vunder` in 1: detector undervoltage flag, asynchronous; high means undervoltage.
- `clear` in 1: one-cycle pulse that clears the sticky flags and the event counter.
- `sys_resetb` out 1: active-low system reset request.
- `pwr_good` out 1: high only in MON.
- `bod_flag` out 1: sticky; a brownout occurred.
- `vunder_flag` out 1: sticky; undervoltage occurred.
- `event_cnt` out CNT_W: count of brownout events, saturating.
- `state` out 2: current FSM state, for debug.

## Operation
- Synchronizers: two-flop chains on `~outb` (`bod_s`) and on `vunder` (`vu_s`). Both chains reset to 0.
- Debounce, per signal, identical logic:
  - Registered level `*_d` resets to 0.
  - A counter increments while the synchronized value differs from `*_d`. It clears on any cycle where they match.
  - When the counter reaches DEB_CYCLES, `*_d` toggles and the counter clears.
  - Glitches shorter than DEB_CYCLES cycles never change `*_d`.
- FSM encoding: IDLE=0, MON=1, FAULT=2, HOLD=3.
  - IDLE: `sys_resetb`=1, `pwr_good`=0. With `ena`=1: go to FAULT if `bod_d`=1, else MON.
  - MON: `sys_resetb`=1, `pwr_good`=1. `bod_d`=1 goes to FAULT and counts one event.
  - FAULT: `sys_resetb`=0. `bod_d`=0 loads the hold counter with 0 and goes to HOLD.
  - HOLD: `sys_resetb`=0. The hold counter increments every cycle. At HOLD_CYCLES-1 the next state is MON. `bod_d`=1 returns to FAULT and is not counted as a new event.
  - In any state, `ena`=0 goes to IDLE next cycle, with priority over every other transition.
- `bod_flag` sets on entry to FAULT from MON or IDLE.
- `vunder_flag` sets on the rising edge of `vu_d`, in any state including IDLE.
- `event_cnt` increments on each MON→FAULT transition and saturates at 2^CNT_W−1 with no wrap.
- `clear`: zeroes both flags and `event_cnt`. If a set or increment occurs in the same cycle, the set/increment wins: flag=1, cnt=1.
- All outputs are registered.

## Timing
- Reset values:
  - state=IDLE, `sys_resetb`=0, `pwr_good`=0, flags=0, `event_cnt`=0, all counters 0.
  - `sys_resetb` rises on the first `clk` edge after `resetb` deasserts, because IDLE drives 1.
- `outb` fall to `sys_resetb` fall, measured in MON: 2 (sync) + DEB_CYCLES + 1 (FSM) cycles. `pwr_good` falls in the same cycle.
- `outb` rise to `sys_resetb` rise: 2 + DEB_CYCLES cycles to `bod_d`=0, then 1 cycle into HOLD, then HOLD_CYCLES cycles in HOLD. `pwr_good` rises together with `sys_resetb`.
- `ena` fall to IDLE: 1 cycle. From FAULT or HOLD, `sys_resetb` rises in that cycle.
- `resetb` asserted mid-HOLD: the hold count is discarded and all outputs return to their reset values immediately.

## Configuration
- `BROWNOUT_SEQ_EVENT_CNT_EN`:
  - Defined: event counter implemented as above.
  - Undefined: no counter flops; `event_cnt` is tied to 0. `clear` still clears the flags.

## Test plan
Bench settings: DEB_CYCLES=4, HOLD_CYCLES=16.

- Reset, then `ena`=1 with `outb`=1:
  - `sys_resetb`=1 one cycle after reset release.
  - State reaches MON and `pwr_good`=1 one cycle after `ena`=1.
- In MON, `outb`=0 held for 40 cycles, then `outb`=1:
  - `sys_resetb` falls 7 cycles after the `outb` edge.
  - `sys_resetb` returns 6+1+16 cycles after `outb` rises.
  - `event_cnt`=1, `bod_flag`=1.
- In MON, `outb` low pulses of 3 cycles, repeated 10 times:
  - No state change, `event_cnt`=0, `bod_flag`=0.
- In HOLD after 8 cycles, `outb`=0 again for 20 cycles:
  - Returns to FAULT, `event_cnt` unchanged.
  - HOLD restarts from 0 and takes the full 16 cycles.
- 300 brownout events with CNT_W=8:
  - `event_cnt` saturates at 255.
  - `clear` pulsed in the same cycle as the 301st event gives `event_cnt`=1 and `bod_flag`=1.
- `vunder` high for 10 cycles while `ena`=0:
  - `vunder_flag`=1, state stays IDLE.
  - Compiled without `BROWNOUT_SEQ_EVENT_CNT_EN`: `event_cnt` stays 0 throughout all scenarios.

Source files
------------

// File: rtl/brownout_reset_sequencer.sv
// Brownout detector back-end: sync + debounce, reset/power-good FSM, sticky flags.
// Optional event counter enabled by defining BROWNOUT_SEQ_EVENT_CNT_EN.

module brownout_reset_deb #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic resetb,
  input  logic s,
  output logic d
);
  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      d   <= 1'b0;
      cnt <= '0;
    end else if (s == d) begin
      cnt <= '0;
    end else if (cnt == DEB_LAST) begin
      d   <= ~d;
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end
endmodule

module brownout_reset_sequencer #(
  parameter int DEB_CYCLES  = 4,
  parameter int HOLD_CYCLES = 1024,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             ena,
  input  logic             outb,
  input  logic             vunder,
  input  logic             clear,
  output logic             sys_resetb,
  output logic             pwr_good,
  output logic             bod_flag,
  output logic             vunder_flag,
  output logic [CNT_W-1:0] event_cnt,
  output logic [1:0]       state
);
  typedef enum logic [1:0] {IDLE = 2'd0, MON = 2'd1, FAULT = 2'd2, HOLD = 2'd3} st_e;

  localparam int         NSIG      = 2;
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

  logic [NSIG-1:0] raw, sync_q1, sync_q2, deb_d;
  logic            bod_d, vu_d, vu_q, bod_set, vu_rise;
  logic [15:0]     hold_cnt;
  st_e             st, nxt;

  // bit 0: brownout (inverted outb), bit 1: undervoltage
  assign raw = {vunder, ~outb};

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  for (genvar g = 0; g < NSIG; g++) begin : g_deb
    brownout_reset_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk    (clk),
      .resetb (resetb),
      .s      (sync_q2[g]),
      .d      (deb_d[g])
    );
  end

  assign bod_d   = deb_d[0];
  assign vu_d    = deb_d[1];
  assign vu_rise = vu_d & ~vu_q;
  assign state   = st;

  always_comb begin
    nxt = st;
    if (!ena) nxt = IDLE;
    else begin
      case (st)
        IDLE:    nxt = bod_d ? FAULT : MON;
        MON:     if (bod_d) nxt = FAULT;
        FAULT:   if (!bod_d) nxt = HOLD;
        HOLD:    if (bod_d) nxt = FAULT;
                 else if (hold_cnt == HOLD_LAST) nxt = MON;
        default: nxt = IDLE;
      endcase
    end
  end

  // Re-entry to FAULT from HOLD is the same brownout, so it does not flag again.
  assign bod_set = (nxt == FAULT) && ((st == MON) || (st == IDLE));

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      st          <= IDLE;
      sys_resetb  <= 1'b0;
      pwr_good    <= 1'b0;
      hold_cnt    <= '0;
      vu_q        <= 1'b0;
      bod_flag    <= 1'b0;
      vunder_flag <= 1'b0;
    end else begin
      st         <= nxt;
      sys_resetb <= !((nxt == FAULT) || (nxt == HOLD));
      pwr_good   <= (nxt == MON);
      vu_q       <= vu_d;
      if (nxt == HOLD && st != HOLD) hold_cnt <= '0;
      else if (st == HOLD)           hold_cnt <= hold_cnt + 16'd1;
      if (bod_set)    bod_flag <= 1'b1;
      else if (clear) bod_flag <= 1'b0;
      if (vu_rise)    vunder_flag <= 1'b1;
      else if (clear) vunder_flag <= 1'b0;
    end
  end

`ifdef BROWNOUT_SEQ_EVENT_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic ev;
  assign ev = (st == MON) && (nxt == FAULT);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb)     event_cnt <= '0;
    else if (ev)     event_cnt <= clear ? CNT_W'(1) :
                                  (event_cnt == CNT_MAX) ? event_cnt : event_cnt + CNT_W'(1);
    else if (clear)  event_cnt <= '0;
  end
`else
  assign event_cnt = '0;
`endif
endmodule
